vu_level_meter: RTL and testbench

//  Converts the equalizer's output audio stream into an 8-segment log-scale level bar for the LED driver.

---
 rtl/vu_pkg.sv | 24 ++
 rtl/vu_thermo.sv | 22 ++
 rtl/vu_level_meter.sv | 137 +++++++++++++
 tb/tb_vu_level_meter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/vu_pkg.sv
// Shared widths, FSM state type and the sample-magnitude helper for the VU level meter.
package vu_pkg;

  localparam int unsigned MAG_W      = 15;
  localparam int unsigned LED_W      = 8;
  localparam int unsigned SMPL_W     = 16;
  localparam int unsigned THERMO_LSB = 7;

  typedef enum logic {ACCUM, UPDATE} vu_state_t;

  // |s| on 15 bits; the single unrepresentable value -32768 clips to 32767.
  function automatic logic [MAG_W-1:0] mag_of(input logic [SMPL_W-1:0] s);
    logic [SMPL_W-1:0] neg;
    neg = -s;
    if (s == {1'b1, (SMPL_W-1)'(0)}) begin
      return '1;
    end else if (s[SMPL_W-1]) begin
      return neg[MAG_W-1:0];
    end else begin
      return s[MAG_W-1:0];
    end
  endfunction

endpackage

// File: rtl/vu_thermo.sv
// Log-scale thermometer encoder: segment k lights once the peak reaches 2^(7+k).
module vu_thermo
  import vu_pkg::*;
(
  input  logic [MAG_W-1:0] max_mag,
  output logic [LED_W-1:0] thermo,
  output logic [3:0]       top
);

  // top counts lit segments (0 = dark), which equals the 1-based index of the top one.
  always_comb begin
    thermo = '0;
    top    = '0;
    for (int k = 0; k < LED_W; k++) begin
      thermo[k] = (max_mag >= (MAG_W'(1) << (THERMO_LSB + k)));
      if (thermo[k]) begin
        top = 4'(k + 1);
      end
    end
  end

endmodule

// File: rtl/vu_level_meter.sv
// Windowed peak detector driving an 8-segment log level bar, one update per window.
// Optional peak-hold dot is built when VU_PEAK_HOLD_EN is defined.
module vu_level_meter
  import vu_pkg::*;
#(
  parameter int unsigned WIN_SAMPLES  = 1024
`ifdef VU_PEAK_HOLD_EN
  , parameter int unsigned HOLD_WINDOWS = 8
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              smpl_vld,
  input  logic [SMPL_W-1:0] smpl,
  output logic [LED_W-1:0]  led_lvl,
  output logic              lvl_vld
);

  localparam int unsigned   CNT_W    = $clog2(WIN_SAMPLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_SAMPLES - 1);

  vu_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAG_W-1:0]   max_q, max_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               vld_q, vld_d;
  logic [MAG_W-1:0]   mag;
  logic [LED_W-1:0]   thermo;
  logic [3:0]         top_idx;

  assign mag = mag_of(smpl);

  vu_thermo u_thermo (
    .max_mag (max_q),
    .thermo  (thermo),
    .top     (top_idx)
  );

`ifdef VU_PEAK_HOLD_EN
  localparam int unsigned HCW = $clog2(HOLD_WINDOWS + 1);

  logic [3:0]       hold_idx_q, hold_idx_d;
  logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [LED_W-1:0] dot;

  // Dot reflects the hold state entering this update, so a drop shows one window late.
  always_comb begin
    dot        = '0;
    hold_idx_d = hold_idx_q;
    hold_cnt_d = hold_cnt_q;
    if (hold_idx_q != 4'd0) begin
      dot = LED_W'(1) << (hold_idx_q - 4'd1);
    end
    if (state_q == UPDATE) begin
      if (top_idx >= hold_idx_q) begin
        hold_idx_d = top_idx;
        hold_cnt_d = HCW'(HOLD_WINDOWS);
      end else if (hold_cnt_q != '0) begin
        hold_cnt_d = hold_cnt_q - HCW'(1);
      end else begin
        hold_idx_d = top_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_idx_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      hold_idx_q <= hold_idx_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  logic [3:0] unused_top_idx;
  assign unused_top_idx = top_idx;
`endif

  // Next-state and datapath; a strobe during UPDATE seeds the following window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    led_d   = led_q;
    vld_d   = 1'b0;
    case (state_q)
      ACCUM: begin
        if (smpl_vld) begin
          if (mag > max_q) begin
            max_d = mag;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = UPDATE;
          end
        end
      end
      UPDATE: begin
        vld_d   = 1'b1;
        state_d = ACCUM;
`ifdef VU_PEAK_HOLD_EN
        led_d   = thermo | dot;
`else
        led_d   = thermo;
`endif
        if (smpl_vld) begin
          max_d = mag;
          cnt_d = CNT_W'(1);
        end else begin
          max_d = '0;
          cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      max_q   <= '0;
      led_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      led_q   <= led_d;
      vld_q   <= vld_d;
    end
  end

  assign led_lvl = led_q;
  assign lvl_vld = vld_q;

endmodule

// File: tb/tb_vu_level_meter.sv
// Directed self-checking bench for vu_level_meter with a 4-sample window.
module tb_vu_level_meter;

  logic        clk;
  logic        rst_n;
  logic        smpl_vld;
  logic [15:0] smpl;
  logic [7:0]  led_lvl;
  logic        lvl_vld;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  vu_level_meter #(
    .WIN_SAMPLES (4)
`ifdef VU_PEAK_HOLD_EN
    , .HOLD_WINDOWS (2)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .smpl_vld (smpl_vld),
    .smpl     (smpl),
    .led_lvl  (led_lvl),
    .lvl_vld  (lvl_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (lvl_vld === 1'b1) pulse_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    smpl     = v;
    smpl_vld = 1'b1;
    step();
    smpl_vld = 1'b0;
    smpl     = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Four strobes, then the pulse must land on the second edge after the last one.
  task automatic window(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d, input logic [7:0] exp);
    send(a);
    send(b);
    send(c);
    send(d);
    check_eq({tag, "_vld_early"}, 32'(lvl_vld), 32'd0);
    step();
    check_eq({tag, "_vld"}, 32'(lvl_vld), 32'd1);
    check_eq({tag, "_led"}, 32'(led_lvl), 32'(exp));
    step();
    check_eq({tag, "_vld_end"}, 32'(lvl_vld), 32'd0);
    check_eq({tag, "_led_hold"}, 32'(led_lvl), 32'(exp));
  endtask

  initial begin
    logic [15:0] t4 [12];
    logic [7:0]  t4_exp [3];
    int          pcyc [$];
    logic [7:0]  pled [$];
    int          p0;

    rst_n    = 1'b0;
    smpl_vld = 1'b0;
    smpl     = '0;

    // 1: reset held with strobes toggling
    for (int i = 0; i < 3; i++) begin
      smpl     = 16'd30000;
      smpl_vld = (i % 2 == 0);
      step();
      check_eq("rst_led", 32'(led_lvl), 32'h00);
      check_eq("rst_vld", 32'(lvl_vld), 32'd0);
    end
    rst_n    = 1'b1;
    smpl_vld = 1'b0;
    step();
    check_eq("post_rst_vld", 32'(lvl_vld), 32'd0);
    check_eq("post_rst_led", 32'(led_lvl), 32'h00);

    // 2: basic window, peak 200
    do_reset();
    window("w200", 16'd100, -16'sd200, 16'd50, 16'd0, 8'h01);

    // 3: saturation and segment boundaries
    do_reset();
    window("sat_neg", 16'h8000, 16'd0, 16'd0, 16'd0, 8'hFF);
    do_reset();
    window("w16383", 16'd16383, 16'd0, 16'd0, 16'd0, 8'h7F);
    do_reset();
    window("w127", 16'd127, -16'sd127, 16'd0, 16'd0, 8'h00);
    do_reset();
    window("w128", -16'sd128, 16'd5, 16'd0, 16'd0, 8'h01);

    // 4: strobes every cycle; 4 samples per window with none dropped gives a 4-cycle period
    do_reset();
    t4 = '{16'd300, 16'd0, 16'd0, 16'd0, 16'd20000, 16'd0, 16'd0, 16'd0,
           16'd1000, 16'd0, 16'd0, 16'd0};
`ifdef VU_PEAK_HOLD_EN
    t4_exp = '{8'h03, 8'hFF, 8'h87};
`else
    t4_exp = '{8'h03, 8'hFF, 8'h07};
`endif
    for (int i = 0; i < 13; i++) begin
      if (i < 12) begin
        smpl     = t4[i];
        smpl_vld = 1'b1;
      end else begin
        smpl_vld = 1'b0;
      end
      step();
      if (lvl_vld === 1'b1) begin
        pcyc.push_back(i);
        pled.push_back(led_lvl);
      end
    end
    smpl_vld = 1'b0;
    check_eq("cont_pulses", 32'(pcyc.size()), 32'd3);
    for (int j = 0; j < 3; j++) begin
      if (j < pcyc.size()) begin
        check_eq($sformatf("cont_cyc%0d", j), 32'(pcyc[j]), 32'(4 * (j + 1)));
        check_eq($sformatf("cont_led%0d", j), 32'(pled[j]), 32'(t4_exp[j]));
      end
    end

    // 5: reset mid-window discards the partial peak
    do_reset();
    p0 = pulse_cnt;
    send(16'd30000);
    send(16'd30000);
    rst_n = 1'b0;
    step();
    check_eq("mid_rst_vld", 32'(lvl_vld), 32'd0);
    rst_n = 1'b1;
    window("mid_rst", 16'd0, 16'd0, 16'd0, 16'd0, 8'h00);
    step();
    step();
    check_eq("mid_rst_pulses", 32'(pulse_cnt - p0), 32'd1);

`ifdef VU_PEAK_HOLD_EN
    // 6: peak-hold dot lingers over the quieter windows, then decays
    do_reset();
    window("hold_ff", 16'h8000, 16'd0, 16'd0, 16'd0, 8'hFF);
    window("hold_1", 16'd200, 16'd0, 16'd0, 16'd0, 8'h81);
    window("hold_2", 16'd200, 16'd0, 16'd0, 16'd0, 8'h81);
    window("hold_3", 16'd200, 16'd0, 16'd0, 16'd0, 8'h81);
    window("hold_4", 16'd200, 16'd0, 16'd0, 16'd0, 8'h01);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
